// File: rtl/code_loader.sv
// Byte-stream program loader: packs little-endian bytes into words and writes
// them sequentially into code memory while holding the CPU idle.
module code_loader #(
  parameter int BIT_WIDTH     = 32,
  parameter int INST_COUNT    = 256,
  parameter int INST_COUNT_L2 = 8
) (
  input  logic                     clk,
  input  logic                     nreset,
  input  logic                     load_start,
  input  logic [INST_COUNT_L2:0]   load_len,
  input  logic                     byte_valid,
  input  logic [7:0]               byte_data,
  output logic                     byte_ready,
  output logic                     wr_en,
  output logic [INST_COUNT_L2-1:0] wr_addr,
  output logic [BIT_WIDTH-1:0]     wr_data,
  output logic                     cpu_hold,
  output logic                     done
);

  localparam int BYTES = BIT_WIDTH / 8;
  localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [INST_COUNT_L2:0] LEN_MAX = (INST_COUNT_L2 + 1)'(INST_COUNT);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BYTES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                     state_reg;
  state_t                     state_next;
  logic [IDX_W-1:0]           idx_reg;
  logic [INST_COUNT_L2:0]     word_cnt_reg;
  logic [INST_COUNT_L2:0]     len_reg;
  logic [INST_COUNT_L2:0]     len_next;
  logic [BIT_WIDTH-1:0]       buf_reg;
  logic [BIT_WIDTH-1:0]       word_next;
  logic                       wr_en_reg;
  logic [INST_COUNT_L2-1:0]   wr_addr_reg;
  logic [BIT_WIDTH-1:0]       wr_data_reg;
  logic                       start_accept;
  logic                       byte_fire;

  assign len_next     = (load_len > LEN_MAX) ? LEN_MAX : load_len;
  assign start_accept = load_start && ((state_reg == S_IDLE) || (state_reg == S_DONE));
  assign byte_fire    = byte_valid && byte_ready;

  // Current byte merged into its lane; the completed word is taken from here
  // so the buffer can start refilling while wr_data is still being written.
  genvar gi;
  generate
    for (gi = 0; gi < BYTES; gi = gi + 1) begin : g_lane
      assign word_next[gi*8 +: 8] = (idx_reg == IDX_W'(gi)) ? byte_data : buf_reg[gi*8 +: 8];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE, S_DONE: begin
        if (load_start) begin
          state_next = (len_next == '0) ? S_DONE : S_LOAD;
        end
      end
      S_LOAD: begin
        // Counter reaches the length exactly in the final write cycle.
        if (word_cnt_reg == len_reg) begin
          state_next = S_DONE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    byte_ready = 1'b0;
    cpu_hold   = 1'b0;
    done       = 1'b0;
    case (state_reg)
      S_LOAD: begin
        byte_ready = (word_cnt_reg != len_reg);
        cpu_hold   = 1'b1;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      idx_reg      <= '0;
      word_cnt_reg <= '0;
      len_reg      <= '0;
      buf_reg      <= '0;
      wr_en_reg    <= 1'b0;
      wr_addr_reg  <= '0;
      wr_data_reg  <= '0;
    end else begin
      wr_en_reg <= 1'b0;
      if (start_accept) begin
        idx_reg      <= '0;
        word_cnt_reg <= '0;
        len_reg      <= len_next;
      end else if (byte_fire) begin
        buf_reg <= word_next;
        if (idx_reg == IDX_LAST) begin
          idx_reg      <= '0;
          wr_en_reg    <= 1'b1;
          wr_data_reg  <= word_next;
          wr_addr_reg  <= word_cnt_reg[INST_COUNT_L2-1:0];
          word_cnt_reg <= word_cnt_reg + 1'b1;
        end else begin
          idx_reg <= idx_reg + IDX_W'(1);
        end
      end
    end
  end

  assign wr_en   = wr_en_reg;
  assign wr_addr = wr_addr_reg;
  assign wr_data = wr_data_reg;

`ifndef SYNTHESIS
  a_wr_in_load: assert property (@(posedge clk) disable iff (!nreset)
    wr_en_reg |-> (state_reg == S_LOAD));
  a_wr_addr_range: assert property (@(posedge clk) disable iff (!nreset)
    wr_en_reg |-> ({1'b0, wr_addr_reg} < LEN_MAX));
`endif

endmodule

// File: tb/tb_code_loader.sv
// Directed self-checking bench for code_loader: reset, streaming, gaps,
// length edge cases, mid-load reset and reload from DONE.
module tb_code_loader;

  logic        clk;
  logic        nreset;
  logic        load_start;
  logic [8:0]  load_len;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [31:0] wr_data;
  logic        cpu_hold;
  logic        done;

  int vectors;
  int miscompares;

  logic [7:0]  wa_q[$];
  logic [31:0] wd_q[$];
  logic        prev_wr;
  int          dbl_wr;

  code_loader #(.BIT_WIDTH(32), .INST_COUNT(256), .INST_COUNT_L2(8)) dut (
    .clk(clk), .nreset(nreset), .load_start(load_start), .load_len(load_len),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .cpu_hold(cpu_hold), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write log sampled mid-cycle; also flags any wr_en lasting two cycles.
  always @(negedge clk) begin
    if (wr_en) begin
      wa_q.push_back(wr_addr);
      wd_q.push_back(wr_data);
      if (prev_wr) dbl_wr++;
    end
    prev_wr = wr_en;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    wa_q.delete();
    wd_q.delete();
    dbl_wr = 0;
  endtask

  task automatic do_reset();
    byte_valid = 1'b0;
    load_start = 1'b0;
    nreset = 1'b0;
    tick();
    tick();
    nreset = 1'b1;
  endtask

  task automatic start_load(input logic [8:0] len);
    load_start = 1'b1;
    load_len   = len;
    tick();
    load_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int guard;
    if (gap > 0) begin
      byte_valid = 1'b0;
      repeat (gap) tick();
    end
    byte_valid = 1'b1;
    byte_data  = b;
    guard = 0;
    @(negedge clk);
    while (!byte_ready && guard < 50) begin
      guard++;
      @(negedge clk);
    end
    if (!byte_ready) begin
      vectors++;
      miscompares++;
      $display("FAIL send_byte timeout: byte_ready=%0b required 1", byte_ready);
    end
    tick();
  endtask

  task automatic wait_done(input string name);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!done && guard < 50) begin
      guard++;
      @(negedge clk);
    end
    vectors++;
    if (done !== 1'b1) begin
      miscompares++;
      $display("FAIL %s wait_done: done=%0b required 1", name, done);
    end
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    nreset = 1'b0;
    tick();
    @(negedge clk);
    vectors++;
    if ({byte_ready, wr_en, cpu_hold, done} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_flags: got %b required 0000", {byte_ready, wr_en, cpu_hold, done});
    end
    vectors++;
    if (wr_addr !== 8'h00 || wr_data !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_bus: addr=%h data=%h required 00/00000000", wr_addr, wr_data);
    end
    tick();
    nreset = 1'b1;
    clear_log();
    byte_valid = 1'b1;
    byte_data  = 8'h5A;
    repeat (3) tick();
    byte_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (byte_ready !== 1'b0 || done !== 1'b0 || cpu_hold !== 1'b0 || wa_q.size() != 0) begin
      miscompares++;
      $display("FAIL idle_ignore: ready=%0b done=%0b hold=%0b writes=%0d required 0/0/0/0",
               byte_ready, done, cpu_hold, wa_q.size());
    end
    $display("test_reset: done");
    tick();
  endtask

  task automatic send_image(input int use_gaps);
    logic [7:0] img [8];
    int gaps [8];
    img  = '{8'h13, 8'h00, 8'hA0, 8'hE3, 8'h01, 8'h10, 8'hA0, 8'hE3};
    gaps = '{0, 3, 5, 1, 2, 4, 0, 5};
    for (int i = 0; i < 8; i++) send_byte(img[i], use_gaps ? gaps[i] : 0);
    byte_valid = 1'b0;
  endtask

  task automatic check_image_writes(input string name);
    vectors++;
    if (wa_q.size() != 2) begin
      miscompares++;
      $display("FAIL %s write_count: got %0d required 2", name, wa_q.size());
    end else begin
      vectors++;
      if (wa_q[0] !== 8'd0 || wd_q[0] !== 32'hE3A00013) begin
        miscompares++;
        $display("FAIL %s word0: addr=%h data=%h required 00/e3a00013", name, wa_q[0], wd_q[0]);
      end
      vectors++;
      if (wa_q[1] !== 8'd1 || wd_q[1] !== 32'hE3A01001) begin
        miscompares++;
        $display("FAIL %s word1: addr=%h data=%h required 01/e3a01001", name, wa_q[1], wd_q[1]);
      end
    end
    vectors++;
    if (done !== 1'b1 || cpu_hold !== 1'b0 || byte_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL %s final: done=%0b hold=%0b ready=%0b required 1/0/0", name, done, cpu_hold, byte_ready);
    end
  endtask

  task automatic test_back_to_back();
    clear_log();
    start_load(9'd2);
    @(negedge clk);
    vectors++;
    if (cpu_hold !== 1'b1 || byte_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_load_entry: hold=%0b ready=%0b required 1/1", cpu_hold, byte_ready);
    end
    tick();
    send_image(0);
    @(negedge clk);
    vectors++;
    if (wr_en !== 1'b1 || byte_ready !== 1'b0 || cpu_hold !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_final_write_cycle: wr_en=%0b ready=%0b hold=%0b required 1/0/1",
               wr_en, byte_ready, cpu_hold);
    end
    tick();
    wait_done("b2b");
    repeat (3) tick();
    @(negedge clk);
    check_image_writes("b2b");
    $display("test_back_to_back: writes=%0d", wa_q.size());
    tick();
  endtask

  task automatic test_gaps();
    clear_log();
    start_load(9'd2);
    send_image(1);
    wait_done("gaps");
    repeat (3) tick();
    @(negedge clk);
    check_image_writes("gaps");
    vectors++;
    if (dbl_wr != 0) begin
      miscompares++;
      $display("FAIL gaps_wr_pulse: multi-cycle wr_en count=%0d required 0", dbl_wr);
    end
    $display("test_gaps: writes=%0d", wa_q.size());
    tick();
  endtask

  task automatic test_len_zero();
    do_reset();
    clear_log();
    start_load(9'd0);
    @(negedge clk);
    vectors++;
    if (done !== 1'b1 || cpu_hold !== 1'b0) begin
      miscompares++;
      $display("FAIL len0_done: done=%0b hold=%0b required 1/0", done, cpu_hold);
    end
    repeat (4) tick();
    vectors++;
    if (wa_q.size() != 0) begin
      miscompares++;
      $display("FAIL len0_writes: got %0d required 0", wa_q.size());
    end
    $display("test_len_zero: writes=%0d", wa_q.size());
  endtask

  task automatic test_clamp();
    int bad;
    clear_log();
    start_load(9'd300);
    for (int w = 0; w < 256; w++) begin
      send_byte(w[7:0], 0);
      send_byte(w[7:0] ^ 8'h55, 0);
      send_byte(8'hA5, 0);
      send_byte(8'h3C, 0);
    end
    byte_valid = 1'b0;
    wait_done("clamp");
    repeat (2) tick();
    vectors++;
    if (wa_q.size() != 256) begin
      miscompares++;
      $display("FAIL clamp_count: got %0d required 256", wa_q.size());
    end else begin
      bad = 0;
      for (int w = 0; w < 256; w++) begin
        if (wa_q[w] !== w[7:0] || wd_q[w] !== {8'h3C, 8'hA5, w[7:0] ^ 8'h55, w[7:0]}) bad++;
      end
      vectors++;
      if (bad != 0) begin
        miscompares++;
        $display("FAIL clamp_words: %0d wrong words required 0", bad);
      end
      vectors++;
      if (wa_q[255] !== 8'hFF || wd_q[255] !== 32'h3CA5AAFF) begin
        miscompares++;
        $display("FAIL clamp_last: addr=%h data=%h required ff/3ca5aaff", wa_q[255], wd_q[255]);
      end
    end
    @(negedge clk);
    vectors++;
    if (byte_ready !== 1'b0 || done !== 1'b1) begin
      miscompares++;
      $display("FAIL clamp_after: ready=%0b done=%0b required 0/1", byte_ready, done);
    end
    $display("test_clamp: writes=%0d", wa_q.size());
    tick();
  endtask

  task automatic test_reset_mid();
    logic [7:0] b6 [6];
    b6 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    clear_log();
    start_load(9'd2);
    for (int i = 0; i < 6; i++) send_byte(b6[i], 0);
    byte_valid = 1'b0;
    nreset = 1'b0;
    tick();
    nreset = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    vectors++;
    if (wa_q.size() != 1 || wa_q[0] !== 8'd0 || wd_q[0] !== 32'h44332211) begin
      miscompares++;
      $display("FAIL midreset_writes: count=%0d required 1 at 00 data 44332211", wa_q.size());
    end
    vectors++;
    if ({byte_ready, cpu_hold, done, wr_en} !== 4'b0000) begin
      miscompares++;
      $display("FAIL midreset_idle: got %b required 0000", {byte_ready, cpu_hold, done, wr_en});
    end
    tick();
    clear_log();
    start_load(9'd1);
    send_byte(8'h78, 0);
    send_byte(8'h56, 0);
    send_byte(8'h34, 0);
    send_byte(8'h12, 0);
    byte_valid = 1'b0;
    wait_done("midreset_fresh");
    vectors++;
    if (wa_q.size() != 1 || wa_q[0] !== 8'd0 || wd_q[0] !== 32'h12345678) begin
      miscompares++;
      $display("FAIL midreset_fresh: count=%0d required 1 at 00 data 12345678", wa_q.size());
    end
    $display("test_reset_mid: writes=%0d", wa_q.size());
  endtask

  task automatic test_reload();
    clear_log();
    @(negedge clk);
    vectors++;
    if (done !== 1'b1) begin
      miscompares++;
      $display("FAIL reload_pre: done=%0b required 1", done);
    end
    tick();
    start_load(9'd1);
    @(negedge clk);
    vectors++;
    if (done !== 1'b0 || cpu_hold !== 1'b1) begin
      miscompares++;
      $display("FAIL reload_entry: done=%0b hold=%0b required 0/1", done, cpu_hold);
    end
    tick();
    send_byte(8'hFF, 0);
    send_byte(8'hFF, 0);
    load_start = 1'b1;
    load_len   = 9'd5;
    send_byte(8'hFF, 0);
    load_start = 1'b0;
    send_byte(8'hEA, 0);
    byte_valid = 1'b0;
    wait_done("reload");
    repeat (2) tick();
    vectors++;
    if (wa_q.size() != 1 || wa_q[0] !== 8'd0 || wd_q[0] !== 32'hEAFFFFFF) begin
      miscompares++;
      $display("FAIL reload_write: count=%0d required 1 at 00 data eaffffff", wa_q.size());
    end
    @(negedge clk);
    vectors++;
    if (done !== 1'b1 || cpu_hold !== 1'b0) begin
      miscompares++;
      $display("FAIL reload_final: done=%0b hold=%0b required 1/0", done, cpu_hold);
    end
    $display("test_reload: writes=%0d", wa_q.size());
    tick();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    prev_wr     = 1'b0;
    dbl_wr      = 0;
    nreset      = 1'b0;
    load_start  = 1'b0;
    load_len    = '0;
    byte_valid  = 1'b0;
    byte_data   = '0;
    #1;
    test_reset();
    test_back_to_back();
    test_gaps();
    test_len_zero();
    test_clamp();
    test_reset_mid();
    test_reload();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
